multichannel_svf: RTL and testbench

//  Time-multiplexed Chamberlin state-variable filter bank: CHANNELS independent audio channels share one

---
 rtl/multichannel_svf.sv | 156 +++++++++++++++
 tb/tb_multichannel_svf.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_svf.sv
// Time-multiplexed Chamberlin state-variable filter bank: CHANNELS filters share one signed
// multiplier, stepping LP -> HP -> BP -> OUT per channel once per accepted sample strobe.
module multichannel_svf #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2,
    parameter int GUARD    = 4,
    parameter int CWIDTH   = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_strobe,
    input  logic [CHANNELS*BITSIZE-1:0]  in,
    input  logic [CHANNELS*CWIDTH-1:0]   F,
    input  logic [CHANNELS*CWIDTH-1:0]   Q1,
    input  logic [CHANNELS*2-1:0]        mode,
    output logic [CHANNELS*BITSIZE-1:0]  out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int SW  = BITSIZE + GUARD;
    localparam int PW  = SW + CWIDTH + 1;
    localparam int AW  = PW + 2;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [AW-1:0] ST_MAX = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] ST_MIN = {{(AW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    localparam logic signed [SW:0]   OUT_MAX = {{(SW-BITSIZE+2){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [SW:0]   OUT_MIN = {{(SW-BITSIZE+2){1'b1}}, {(BITSIZE-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LP, S_HP, S_BP, S_OUT, S_DONE} state_t;

    state_t state, state_nxt;
    logic [CHW-1:0] ch;
    logic [CHANNELS*BITSIZE-1:0] in_q;
    logic [CHANNELS*CWIDTH-1:0]  f_q, q1_q;
    logic [CHANNELS*2-1:0]       mode_q;
    logic signed [SW-1:0] low_r  [CHANNELS];
    logic signed [SW-1:0] band_r [CHANNELS];
    logic signed [SW-1:0] high_r [CHANNELS];

    logic accept, last_ch;
    logic [CWIDTH-1:0]    coef;
    logic signed [SW-1:0] opnd;
    logic signed [PW-1:0] coef_x, opnd_x, prod, term;
    logic [BITSIZE-1:0]   in_c;
    logic signed [AW-1:0] in_x, low_x, band_x, term_x, acc;
    logic signed [SW-1:0] new_val;
    logic signed [SW:0]   sel;
    logic [BITSIZE-1:0]   out_val;

    function automatic logic signed [SW-1:0] sat_state(input logic signed [AW-1:0] v);
        if (v > ST_MAX)      return {1'b0, {(SW-1){1'b1}}};
        else if (v < ST_MIN) return {1'b1, {(SW-1){1'b0}}};
        else                 return v[SW-1:0];
    endfunction

    function automatic logic [BITSIZE-1:0] clamp_out(input logic signed [SW:0] v);
        if (v > OUT_MAX)      return {1'b0, {(BITSIZE-1){1'b1}}};
        else if (v < OUT_MIN) return {1'b1, {(BITSIZE-1){1'b0}}};
        else                  return v[BITSIZE-1:0];
    endfunction

    // A strobe during the out_valid cycle still sees busy=1, so it counts as an overrun.
    assign accept  = (state == S_IDLE) && sample_strobe && !busy;
    assign last_ch = (ch == CHW'(CHANNELS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LP;
            S_LP:    state_nxt = S_HP;
            S_HP:    state_nxt = S_BP;
            S_BP:    state_nxt = S_OUT;
            S_OUT:   state_nxt = last_ch ? S_DONE : S_LP;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single shared multiplier: Q1*band in S_HP, F*high in S_BP, F*band otherwise.
    always_comb begin
        coef = f_q[ch*CWIDTH +: CWIDTH];
        opnd = band_r[ch];
        if (state == S_HP) coef = q1_q[ch*CWIDTH +: CWIDTH];
        if (state == S_BP) opnd = high_r[ch];
        coef_x = {{(PW-CWIDTH){1'b0}}, coef};
        opnd_x = {{(PW-SW){opnd[SW-1]}}, opnd};
        prod   = coef_x * opnd_x;
        term   = (state == S_HP) ? (prod >>> (CWIDTH-2)) : (prod >>> (CWIDTH-1));
        term_x = {{(AW-PW){term[PW-1]}}, term};
        in_c   = in_q[ch*BITSIZE +: BITSIZE];
        in_x   = {{(AW-BITSIZE){in_c[BITSIZE-1]}}, in_c};
        low_x  = {{(AW-SW){low_r[ch][SW-1]}}, low_r[ch]};
        band_x = {{(AW-SW){band_r[ch][SW-1]}}, band_r[ch]};
        case (state)
            S_HP:    acc = in_x - low_x - term_x;
            S_BP:    acc = band_x + term_x;
            default: acc = low_x + term_x;
        endcase
        new_val = sat_state(acc);
        case (mode_q[ch*2 +: 2])
            2'b00:   sel = {low_r[ch][SW-1], low_r[ch]};
            2'b01:   sel = {high_r[ch][SW-1], high_r[ch]};
            2'b10:   sel = {band_r[ch][SW-1], band_r[ch]};
            default: sel = {high_r[ch][SW-1], high_r[ch]} + {low_r[ch][SW-1], low_r[ch]};
        endcase
        out_val = clamp_out(sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch        <= '0;
            in_q      <= '0;
            f_q       <= '0;
            q1_q      <= '0;
            mode_q    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                low_r[i]  <= '0;
                band_r[i] <= '0;
                high_r[i] <= '0;
            end
        end else begin
            out_valid <= (state == S_DONE);
            overrun   <= sample_strobe && busy;
            if (accept)         busy <= 1'b1;
            else if (out_valid) busy <= 1'b0;
            if (accept) begin
                in_q   <= in;
                f_q    <= F;
                q1_q   <= Q1;
                mode_q <= mode;
                ch     <= '0;
            end
            case (state)
                S_LP:  low_r[ch]  <= new_val;
                S_HP:  high_r[ch] <= new_val;
                S_BP:  band_r[ch] <= new_val;
                S_OUT: begin
                    out[ch*BITSIZE +: BITSIZE] <= out_val;
                    if (!last_ch) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multichannel_svf.sv
// Bench for multichannel_svf: hand-computed first-sample vectors, latency/overrun/reset
// sequences, and a per-frame reference model scoreboard for multi-sample runs.
module tb_multichannel_svf;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_strobe = 1'b0;
    logic [31:0] in_s = '0;
    logic [35:0] f_s = '0;
    logic [35:0] q_s = '0;
    logic [3:0]  mode_s = '0;
    logic [31:0] out;
    logic        out_valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    longint m_low[2], m_band[2], m_high[2];

    multichannel_svf dut (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .in(in_s),
        .F(f_s), .Q1(q_s), .mode(mode_s), .out(out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i0, i1, f0, f1, q0, q1, m0, m1;
        int e0, e1;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic longint sat20(input longint v);
        if (v > 524287)  return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    task automatic model_step(input int c, input longint x, input longint f, input longint q,
                              input int m, output longint y);
        longint s;
        m_low[c]  = sat20(m_low[c] + ((f * m_band[c]) >>> 17));
        m_high[c] = sat20(x - m_low[c] - ((q * m_band[c]) >>> 16));
        m_band[c] = sat20(m_band[c] + ((f * m_high[c]) >>> 17));
        case (m)
            0:       s = m_low[c];
            1:       s = m_high[c];
            2:       s = m_band[c];
            default: s = m_high[c] + m_low[c];
        endcase
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        y = s;
    endtask

    function automatic longint ch_out(input int c);
        logic [15:0] v;
        v = out[c*16 +: 16];
        return longint'($signed(v));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_strobe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_low[c] = 0; m_band[c] = 0; m_high[c] = 0;
        end
    endtask

    task automatic drive(input int i0, i1, f0, f1, q0, q1, m0, m1);
        in_s   = {16'(i1), 16'(i0)};
        f_s    = {18'(f1), 18'(f0)};
        q_s    = {18'(q1), 18'(q0)};
        mode_s = {2'(m1), 2'(m0)};
    endtask

    // One accepted frame: model predicts, pins are scrambled mid-run, outputs compared at out_valid.
    task automatic frame(input int i0, i1, f0, f1, q0, q1, m0, m1, input string tag);
        longint y0, y1;
        logic [31:0] e;
        logic [15:0] e0, e1;
        int n;
        @(negedge clk);
        drive(i0, i1, f0, f1, q0, q1, m0, m1);
        sample_strobe = 1'b1;
        model_step(0, i0, f0, q0, m0, y0);
        model_step(1, i1, f1, q1, m1, y1);
        exp_q.push_back({16'(y1), 16'(y0)});
        @(negedge clk);
        sample_strobe = 1'b0;
        in_s   = $urandom();
        f_s    = {4'h0, $urandom()};
        q_s    = {4'h0, $urandom()};
        mode_s = 4'($urandom_range(0, 15));
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        if (out_valid !== 1'b1) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            e0 = e[15:0];
            e1 = e[31:16];
            check({tag, "_ch0"}, ch_out(0), longint'($signed(e0)));
            check({tag, "_ch1"}, ch_out(1), longint'($signed(e1)));
        end
    endtask

    vec_t vecs[6];
    longint ya, yb;
    int seen, x;

    initial begin
        // First sample from cleared state: LP=0, HP=in, BP=floor(F*in/2^17), notch=in.
        vecs[0] = '{1000, -1001, 'h04000, 'h04000, 'h10000, 'h10000, 2, 2, 125, -126};
        vecs[1] = '{8000, -8000, 'h04000, 'h04000, 'h10000, 'h10000, 0, 1, 0, -8000};
        vecs[2] = '{32767, -32768, 'h3FFFF, 'h3FFFF, 'h10000, 'h10000, 2, 2, 32767, -32768};
        vecs[3] = '{1234, -4321, 'h04000, 'h00800, 'h10000, 'h10000, 3, 3, 1234, -4321};
        vecs[4] = '{5000, -7, 0, 0, 'h10000, 'h10000, 1, 2, 5000, 0};
        vecs[5] = '{-32768, 32767, 'h10000, 'h10000, 0, 0, 1, 1, -32768, 32767};

        do_reset();
        @(negedge clk);
        check("reset_out", longint'(out), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(out_valid), 0);
        check("reset_overrun", longint'(overrun), 0);

        foreach (vecs[i]) begin
            do_reset();
            frame(vecs[i].i0, vecs[i].i1, vecs[i].f0, vecs[i].f1, vecs[i].q0, vecs[i].q1,
                  vecs[i].m0, vecs[i].m1, "vec");
            check($sformatf("vec%0d_ch0", i), ch_out(0), vecs[i].e0);
            check($sformatf("vec%0d_ch1", i), ch_out(1), vecs[i].e1);
        end

        // Three-sample recursion, in=8000, F=0.125, Q1=1.0: low 0,125,357; band 1000,1859,2582.
        do_reset();
        frame(8000, 8000, 'h04000, 'h04000, 'h10000, 'h10000, 0, 2, "seq1");
        check("seq1_lp", ch_out(0), 0);
        check("seq1_bp", ch_out(1), 1000);
        frame(8000, 8000, 'h04000, 'h04000, 'h10000, 'h10000, 0, 2, "seq2");
        check("seq2_lp", ch_out(0), 125);
        check("seq2_bp", ch_out(1), 1859);
        frame(8000, 8000, 'h04000, 'h04000, 'h10000, 'h10000, 0, 2, "seq3");
        check("seq3_lp", ch_out(0), 357);
        check("seq3_bp", ch_out(1), 2582);

        // Latency: out_valid exactly 4*CHANNELS+1 cycles after the accepting edge.
        do_reset();
        @(negedge clk);
        drive(100, 200, 'h04000, 'h04000, 'h10000, 'h10000, 1, 1);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        check("lat_busy_0", longint'(busy), 1);
        check("lat_valid_0", longint'(out_valid), 0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            check($sformatf("lat_busy_%0d", n), longint'(busy), (n <= 9) ? 1 : 0);
            check($sformatf("lat_valid_%0d", n), longint'(out_valid), (n == 9) ? 1 : 0);
        end

        // Overrun: second strobe three cycles in is dropped; strobe in out_valid cycle too.
        do_reset();
        @(negedge clk);
        drive(2000, 3000, 'h04000, 'h04000, 'h10000, 'h10000, 1, 1);
        sample_strobe = 1'b1;
        model_step(0, 2000, 'h04000, 'h10000, 1, ya);
        model_step(1, 3000, 'h04000, 'h10000, 1, yb);
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (2) @(negedge clk);
        drive(-5, -5, 'h3FFFF, 'h3FFFF, 0, 0, 3, 3);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        check("ovr_pulse", longint'(overrun), 1);
        @(negedge clk);
        check("ovr_single", longint'(overrun), 0);
        seen = 0;
        while (out_valid !== 1'b1 && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("ovr_valid_seen", longint'(out_valid), 1);
        check("ovr_out_ch0", ch_out(0), ya);
        check("ovr_out_ch1", ch_out(1), yb);
        check("ovr_hand_ch0", ch_out(0), 2000);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        check("ovr_coincident", longint'(overrun), 1);
        check("ovr_coinc_busy", longint'(busy), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("ovr_no_run", seen, 0);
        frame(-1500, 700, 'h04000, 'h04000, 'h10000, 'h10000, 0, 2, "ovr_next");

        // Reset mid-run: aborts, clears out, emits no out_valid, next run starts from zero state.
        @(negedge clk);
        drive(9000, 9000, 'h04000, 'h04000, 'h10000, 'h10000, 1, 1);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_low[c] = 0; m_band[c] = 0; m_high[c] = 0;
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("rst_out", longint'(out), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_no_valid", seen, 0);
        frame(4000, 4000, 'h04000, 'h04000, 'h10000, 'h10000, 1, 3, "rst_next");
        check("rst_next_hand", ch_out(1), 4000);

        // DC step: floor truncation leaves band and high resting anywhere in 0..7 LSB.
        do_reset();
        for (int n = 0; n < 400; n++)
            frame(16384, 16384, 'h04000, 'h04000, 'h10000, 'h10000, 0, 1, "dc");
        check_range("dc_lp", ch_out(0), 16384 - 16, 16384 + 16);
        check_range("dc_hp", ch_out(1), -16, 16);
        frame(16384, 16384, 'h04000, 'h04000, 'h10000, 'h10000, 0, 2, "dc_bp");
        check_range("dc_bp_tol", ch_out(1), -16, 16);

        // Channel independence: ch1 coefficients change halfway, ch0 must follow its own model.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            x = $rtoi(20000.0 * $sin(6.283185307179586 * n / 40.0));
            frame(x, x, 'h04000, (n < 40) ? 'h00800 : 'h08000, 'h10000,
                  (n < 40) ? 'h10000 : 'h08000, 0, 1, "sine");
        end

        // Saturation: full-scale square, Q1=0, F=0.5; state and outputs clamp, never wrap.
        do_reset();
        for (int n = 0; n < 96; n++) begin
            x = (((n / 16) % 2) == 0) ? 32767 : -32767;
            frame(x, x, 'h10000, 'h10000, 0, 0, 2, 0, "sq");
            if (n == 15) check_range("sq_peak_bp", ch_out(0), 0, 32767);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
